// File: rtl/const_unit_pkg.sv
// Shared encodings for the pipelined constant unit: immediate modes and CONCAT sequencer states.
package const_unit_pkg;

  localparam logic [1:0] MODE_ZF     = 2'b00;
  localparam logic [1:0] MODE_SE     = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_CONCAT = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/const_extend.sv
// Combinational widening of an immediate to DATA_W bits for the selected mode.
// CONCAT output is the sign extension of {hi, im}; the caller decides when that beat is meaningful.
module const_extend #(
  parameter int IMM_W  = 15,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]  im,
  input  logic [1:0]        mode,
  input  logic [IMM_W-1:0]  hi,
  output logic [DATA_W-1:0] value
);
  import const_unit_pkg::*;

  always_comb begin
    value = '0;
    unique case (mode)
      MODE_ZF:    value = DATA_W'(im);
      MODE_SE:    value = DATA_W'($signed(im));
      MODE_UPPER: value = DATA_W'(im) << (DATA_W - IMM_W);
      default:    value = DATA_W'($signed({hi, im}));
    endcase
  end

endmodule

// File: rtl/const_unit_pipe.sv
// Pipelined immediate/constant generator with one registered output stage and valid/ready handshake.
// Optional OUT_ZERO/OUT_NEG flag outputs are present when CONST_FLAGS_EN is defined.
module const_unit_pipe #(
  parameter int IMM_W  = 15,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [IMM_W-1:0]  IM,
  input  logic [1:0]        MODE,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              FLUSH,
  output logic [DATA_W-1:0] SEorZF,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              ERR
`ifdef CONST_FLAGS_EN
  ,
  output logic              OUT_ZERO,
  output logic              OUT_NEG
`endif
);
  import const_unit_pkg::*;

  logic [0:0]        state;
  logic [IMM_W-1:0]  hi;
  logic [DATA_W-1:0] ext_value;
  logic              accept;
  logic              is_concat;
  logic              take_hi;
  logic              load;
  logic              abort;

  assign IN_READY  = ~OUT_VALID | OUT_READY;
  assign accept    = IN_VALID & IN_READY;
  assign is_concat = (MODE == MODE_CONCAT);
  // The first CONCAT beat only parks the high half; every other accepted beat produces a result.
  assign take_hi   = accept & is_concat & (state == ST_IDLE);
  assign load      = accept & ~take_hi;
  assign abort     = accept & ~is_concat & (state == ST_HOLD);

  const_extend #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_extend (
    .im    (IM),
    .mode  (MODE),
    .hi    (hi),
    .value (ext_value)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      hi        <= '0;
      SEorZF    <= '0;
      OUT_VALID <= 1'b0;
      ERR       <= 1'b0;
    end else if (FLUSH) begin
      state     <= ST_IDLE;
      OUT_VALID <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      ERR <= abort;
      if (load) begin
        SEorZF    <= ext_value;
        OUT_VALID <= 1'b1;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      if (take_hi) begin
        hi <= IM;
      end
      if (accept) begin
        state <= take_hi ? ST_HOLD : ST_IDLE;
      end
    end
  end

`ifdef CONST_FLAGS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_ZERO <= 1'b0;
      OUT_NEG  <= 1'b0;
    end else if (!FLUSH && load) begin
      OUT_ZERO <= (ext_value == '0);
      OUT_NEG  <= ext_value[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_const_unit_pipe.sv
// Bench for const_unit_pipe (IMM_W=15, DATA_W=32): spec-level model checked every cycle plus directed literals.
module tb_const_unit_pipe;

  logic        CLK;
  logic        RST_N;
  logic [14:0] IM;
  logic [1:0]  MODE;
  logic        IN_VALID;
  logic        IN_READY;
  logic        FLUSH;
  logic [31:0] SEorZF;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        ERR;

  int total = 0;
  int bad   = 0;

  const_unit_pipe #(.IMM_W(15), .DATA_W(32)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IM        (IM),
    .MODE      (MODE),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .FLUSH     (FLUSH),
    .SEorZF    (SEorZF),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .ERR       (ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected constant from plain arithmetic on the mode rules.
  function automatic logic [31:0] model(input logic [1:0] m, input logic [14:0] i, input logic [14:0] h);
    logic [31:0] v;
    case (m)
      2'b00:   v = {17'd0, i};
      2'b01:   v = i[14] ? (32'hFFFF_8000 | {17'd0, i}) : {17'd0, i};
      2'b10:   v = {17'd0, i} * 32'd131072;
      default: begin
        v = {17'd0, h} * 32'd32768 + {17'd0, i};
        if (h[14]) v = v | 32'hC000_0000;
      end
    endcase
    return v;
  endfunction

  logic        m_valid = 1'b0;
  logic [31:0] m_val   = 32'h0;
  logic        m_err   = 1'b0;
  logic        m_pend  = 1'b0;
  logic [14:0] m_hi    = 15'h0;
  logic        m_acc;

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_valid = 1'b0; m_val = 32'h0; m_err = 1'b0; m_pend = 1'b0;
    end else if (FLUSH) begin
      m_valid = 1'b0; m_err = 1'b0; m_pend = 1'b0;
    end else begin
      m_acc = IN_VALID && (!m_valid || OUT_READY);
      m_err = 1'b0;
      if (m_acc && MODE == 2'b11 && !m_pend) begin
        m_pend = 1'b1;
        m_hi   = IM;
        if (OUT_READY) m_valid = 1'b0;
      end else if (m_acc) begin
        if (m_pend && MODE != 2'b11) m_err = 1'b1;
        m_val   = model(MODE, IM, m_hi);
        m_valid = 1'b1;
        m_pend  = 1'b0;
      end else if (OUT_READY) begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("m_out_valid", {31'd0, OUT_VALID}, {31'd0, m_valid});
    chk("m_err", {31'd0, ERR}, {31'd0, m_err});
    chk("m_in_ready", {31'd0, IN_READY}, {31'd0, (!m_valid || OUT_READY)});
    chk("m_seorzf", SEorZF, m_val);
  end

  task automatic beat(input logic [1:0] m, input logic [14:0] i);
    @(negedge CLK);
    MODE = m; IM = i; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; IM = '0; MODE = 2'b00; IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_val", SEorZF, 32'h0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    RST_N = 1'b1;

    beat(2'b01, 15'h4000); chk("se", SEorZF, 32'hFFFF_C000); chk("se_vld", {31'd0, OUT_VALID}, 32'd1);
    beat(2'b00, 15'h4000); chk("zf", SEorZF, 32'h0000_4000);
    beat(2'b10, 15'h0001); chk("upper1", SEorZF, 32'h0002_0000);
    beat(2'b10, 15'h7FFF); chk("upper7fff", SEorZF, 32'hFFFE_0000);

    beat(2'b11, 15'h0001); chk("hi_no_out", {31'd0, OUT_VALID}, 32'd0);
    beat(2'b11, 15'h0002); chk("concat1", SEorZF, 32'h0000_8002);
    beat(2'b11, 15'h4000); chk("hi_no_out2", {31'd0, OUT_VALID}, 32'd0);
    beat(2'b11, 15'h0000); chk("concat2", SEorZF, 32'hE000_0000);

    // Backpressure: one result parked, next beat held off for three cycles.
    @(negedge CLK);
    OUT_READY = 1'b0; MODE = 2'b00; IM = 15'h0011; IN_VALID = 1'b1;
    @(negedge CLK);
    chk("bp_first", SEorZF, 32'h11); chk("bp_vld", {31'd0, OUT_VALID}, 32'd1);
    IM = 15'h0022;
    repeat (3) begin
      @(negedge CLK);
      chk("bp_in_ready", {31'd0, IN_READY}, 32'd0);
      chk("bp_hold", SEorZF, 32'h11);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("bp_rel1", SEorZF, 32'h22); IM = 15'h0033;
    @(negedge CLK);
    chk("bp_rel2", SEorZF, 32'h33); chk("bp_rel2_vld", {31'd0, OUT_VALID}, 32'd1);
    IN_VALID = 1'b0;
    @(negedge CLK);

    // Abort of a pending CONCAT.
    beat(2'b11, 15'h1234);
    beat(2'b00, 15'h0005);
    chk("abort_err", {31'd0, ERR}, 32'd1); chk("abort_val", SEorZF, 32'h0000_0005);
    @(negedge CLK);
    chk("abort_err_pulse", {31'd0, ERR}, 32'd0);

    // Reset while HOLD drops the high half silently.
    beat(2'b11, 15'h1234);
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK);
    chk("rst_hold_vld", {31'd0, OUT_VALID}, 32'd0); chk("rst_hold_val", SEorZF, 32'h0);
    RST_N = 1'b1;
    beat(2'b11, 15'h0001); chk("rst_hi_no_out", {31'd0, OUT_VALID}, 32'd0);
    beat(2'b11, 15'h0002); chk("rst_concat", SEorZF, 32'h0000_8002); chk("rst_concat_err", {31'd0, ERR}, 32'd0);
    @(negedge CLK);

    // Flush with a parked result keeps the value but drops valid.
    OUT_READY = 1'b0;
    beat(2'b00, 15'h0007); chk("fl_vld_before", {31'd0, OUT_VALID}, 32'd1);
    @(negedge CLK); FLUSH = 1'b1;
    @(negedge CLK); FLUSH = 1'b0;
    chk("fl_vld", {31'd0, OUT_VALID}, 32'd0); chk("fl_val", SEorZF, 32'h7);
    OUT_READY = 1'b1;

    // Flush while HOLD: the next CONCAT beat starts a fresh pair.
    beat(2'b11, 15'h1234);
    @(negedge CLK); FLUSH = 1'b1;
    @(negedge CLK); FLUSH = 1'b0;
    beat(2'b11, 15'h0001); chk("fl_hi_no_out", {31'd0, OUT_VALID}, 32'd0);
    beat(2'b11, 15'h0002); chk("fl_concat", SEorZF, 32'h0000_8002); chk("fl_concat_err", {31'd0, ERR}, 32'd0);

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
